// File: rtl/range_bus_deserializer.sv
// range_bus_deserializer: rebuilds serial bits into a word presented on a
// descending [HI:LO] bus and an ascending [LO:HI] bus, with framing-error count.
module range_bus_deserializer #(
   parameter int HI    = 2,
   parameter int LO    = -2,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_sof,
   input  logic             s_data,
   output logic             s_ready,
   output logic [HI:LO]     o_desc,
   output logic [LO:HI]     o_asc,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);
   localparam int WIDTH = HI - LO + 1;
   localparam int CW    = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n, pos;
   logic [WIDTH-1:0] w, w_n;
   logic             gap, gap_n, err_n, accept;

   // gap blocks input for the cycle after a handshake, so HOLD never skids
   assign s_ready = state != HOLD && !gap;
   assign o_valid = state == HOLD;
   assign accept  = s_valid && s_ready;
   assign pos     = s_sof ? '0 : cnt;
   assign o_desc  = w;

   for (genvar k = 0; k < WIDTH; k++) begin : g_asc
      assign o_asc[LO+k] = w[WIDTH-1-k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         w       <= '0;
         gap     <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         w       <= w_n;
         gap     <= gap_n;
         err     <= err_n;
         err_cnt <= (err_n && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      w_n     = w;
      gap_n   = 1'b0;
      err_n   = 1'b0;
      if (state == HOLD) begin
         if (o_ready) begin
            state_n = IDLE;
            gap_n   = 1'b1;
         end
      end else if (accept) begin
         if (state == IDLE && !s_sof) begin
            err_n = 1'b1;
         end else begin
            // a sof inside a word restarts it at bit 0 and counts as an error
            err_n = state == SHIFT && s_sof;
            for (int i = 0; i < WIDTH; i++)
               if (int'(pos) == i) w_n[WIDTH-1-i] = s_data;
            cnt_n   = pos + 1'b1;
            state_n = (int'(pos) == WIDTH - 1) ? HOLD : SHIFT;
         end
      end
   end
endmodule
